axi_burst_addr_gen: RTL
=======================

Name: axi_burst_addr_gen

Overview:
- Parametrised AXI4 burst expander. Accepts one AW/AR-style burst command and emits one beat descriptor per data beat: address, byte-lane strobe, index and last flag.
- Supports FIXED, INCR and WRAP bursts, narrow transfers and unaligned start addresses.
- Shared front end for the slave write-data and read-data paths, sitting between the address-channel skid buffer and the data-channel logic.
- Generalised over data, address, ID and length widths.

Parameters:
- AXI_DW, 128: data bus width in bits; power of 2, 8..1024.
- AXI_AW, 40: address width.
- AXI_IW, 8: ID width.
- AXI_LW, 8: burst length field width.
- AXI_SW, 3: size field width.
- AXI_BURSTW, 2: burst type field width.
- AXI_WSTRBW, AXI_DW/8: byte lanes (derived).

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  reset, asynchronous, active-low
- CMD_VALID  in  1  command valid
- CMD_READY  out  1  command ready
- CMD_ID  in  AXI_IW  transaction ID
- CMD_ADDR  in  AXI_AW  start address
- CMD_LEN  in  AXI_LW  beats minus 1
- CMD_SIZE  in  AXI_SW  log2 bytes per beat
- CMD_BURST  in  AXI_BURSTW  burst type
- BEAT_VALID  out  1  beat descriptor valid
- BEAT_READY  in  1  beat consumed
- BEAT_ID  out  AXI_IW  latched CMD_ID
- BEAT_ADDR  out  AXI_AW  beat address
- BEAT_STRB  out  AXI_WSTRBW  active byte lanes
- BEAT_IDX  out  AXI_LW  beat number, 0-based
- BEAT_LAST  out  1  final beat
- CMD_ERR  out  1  protocol-violation pulse (see Optional Feature)

Behaviour:
- Clock and reset: one clock, ACLK. ARESETn is asynchronous, active-low.
- Reset values: state IDLE; CMD_READY=1 after reset release; BEAT_VALID=0; all BEAT_* outputs 0; CMD_ERR=0.
- FSM, IDLE:
  - CMD_READY=1, BEAT_VALID=0.
  - On CMD_VALID&CMD_READY: latch the command, go to BURST.
  - Beat 0 is presented the next cycle. Latency is 1 cycle from acceptance.
- FSM, BURST:
  - CMD_READY=0, BEAT_VALID=1.
  - Each BEAT_VALID&BEAT_READY advances to the next beat.
  - The handshake on the beat with BEAT_LAST=1 returns the FSM to IDLE.
  - Throughput: 1 beat/cycle, with one idle cycle between bursts.
- Backpressure: while BEAT_VALID&!BEAT_READY, all BEAT_* outputs are held stable.
- Beat size:
  - nbytes = 1<<CMD_SIZE.
  - CMD_SIZE > log2(AXI_WSTRBW) is clamped to log2(AXI_WSTRBW).
  - aligned = addr with the low CMD_SIZE bits cleared.
- Addresses:
  - Beat 0: BEAT_ADDR = CMD_ADDR, unaligned value passed through as given.
  - FIXED (2'b00): every beat uses CMD_ADDR.
  - INCR (2'b01): beat n>0 uses aligned(CMD_ADDR) + n*nbytes. Arithmetic is modulo 2^AXI_AW.
  - WRAP (2'b10):
    - wrap_bytes = nbytes*(CMD_LEN+1); lower = CMD_ADDR with the low log2(wrap_bytes) bits cleared.
    - Next address = aligned + nbytes; if it equals lower + wrap_bytes it becomes lower.
    - Legal only for LEN in {1,3,7,15}. Any other LEN is executed as INCR.
  - Reserved (2'b11): executed as INCR.
- BEAT_STRB:
  - Lanes from (BEAT_ADDR mod AXI_WSTRBW) up to (aligned mod AXI_WSTRBW) + nbytes - 1 are set; all other lanes are 0.
  - Unaligned beat 0 therefore clears the lower lanes.
- BEAT_IDX: 0..CMD_LEN. BEAT_LAST = (BEAT_IDX == latched LEN). LEN=0 gives a single beat with LAST=1.
- Reset mid-burst: asserting ARESETn immediately forces IDLE, BEAT_VALID=0 and the reset values; the in-flight burst is discarded.

Optional Feature:
- Macro: AXI_4K_CHECK_EN.
- Defined:
  - CMD_ERR pulses high for exactly one cycle, the cycle after acceptance, when any of these hold:
    - an INCR burst crosses a 4 KB boundary;
    - a WRAP burst has an illegal LEN;
    - a WRAP start address is not aligned to nbytes.
  - The burst is still executed as specified above.
- Undefined: the CMD_ERR port remains and is tied to 0; no check logic is built.

Decomposition:
- axi_pkg gains:
  - typedef enum logic [AXI_BURSTW-1:0] burst_t {BURST_FIXED=2'b00, BURST_INCR=2'b01, BURST_WRAP=2'b10, BURST_RSVD=2'b11};
  - constant AXI_4KB=4096;
  - constant AXI_SIZE_MAX=$clog2(AXI_WSTRBW).
- One combinational sub-module, axi_strb_gen, computes the lane mask from (addr, size). It is reused by the master-side data path.

Test Plan (AXI_DW=128):
- INCR, addr 0x1004, len 3, size 4 -> BEAT_ADDR 0x1004, 0x1010, 0x1020, 0x1030; BEAT_STRB 0xFFF0, 0xFFFF, 0xFFFF, 0xFFFF; LAST only on IDX 3; beat 0 appears 1 cycle after acceptance.
- WRAP, addr 0x1030, len 3, size 4 -> 0x1030, 0x1000, 0x1010, 0x1020; all STRB 0xFFFF.
- FIXED, addr 0x2002, len 2, size 1 -> 0x2002 three times, each STRB 0x000C; narrow INCR addr 0x0F, len 3, size 0 -> 0x0F, 0x10, 0x11, 0x12 with STRB 0x8000, 0x0001, 0x0002, 0x0004.
- Backpressure and back-to-back:
  - BEAT_READY low for 3 cycles at IDX 1 -> outputs unchanged throughout.
  - Second command held valid during the burst -> accepted only in the IDLE cycle after the LAST handshake.
- Reset mid-burst: ARESETn low at IDX 2 of len 7 -> BEAT_VALID=0 asynchronously; after release, CMD_READY=1 and a new len 0 command yields a single beat with LAST=1.
- AXI_4K_CHECK_EN defined:
  - INCR 0x0FF0, len 1, size 4 -> CMD_ERR one-cycle pulse; beats 0x0FF0, 0x1000.
  - WRAP len 2 -> CMD_ERR pulse, executed as INCR.
  - Undefined -> CMD_ERR stays 0.

Source files
------------

// File: rtl/axi_pkg.sv
`default_nettype none
// axi_pkg: shared AXI4 burst-type encoding and constants for the burst expander and strobe generator.
package axi_pkg;

   localparam int AXI_BURST_TW = 2;

   typedef enum logic [AXI_BURST_TW-1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } burst_t;

   localparam int AXI_4KB = 4096;

   // Largest legal CMD_SIZE for a bus with the given number of byte lanes.
   function automatic int axi_size_max(input int wstrbw);
      return $clog2(wstrbw);
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi_strb_gen.sv
`default_nettype none
// axi_strb_gen: byte-lane mask for one beat, from the in-bus address offset and the beat size.
module axi_strb_gen #(
   parameter int AXI_WSTRBW = 16,
   parameter int AXI_SW     = 3,
   parameter int OFFW       = ($clog2(AXI_WSTRBW) > 0) ? $clog2(AXI_WSTRBW) : 1
) (
   input  logic [OFFW-1:0]       addr,
   input  logic [AXI_SW-1:0]     size,
   output logic [AXI_WSTRBW-1:0] strb
);

   int lo;
   int hi;
   int nb;

   // Lanes run from the raw offset up to the end of the size-aligned container.
   always_comb begin
      strb = '0;
      nb   = 1 << int'(size);
      lo   = (AXI_WSTRBW > 1) ? int'(addr) : 0;
      hi   = (lo & ~(nb - 1)) + nb - 1;
      for (int i = 0; i < AXI_WSTRBW; i++) begin
         strb[i] = (i >= lo) && (i <= hi);
      end
   end

endmodule
`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
`default_nettype none
// axi_burst_addr_gen: expands one AXI4 burst command into per-beat address/strobe/index/last descriptors.
// Optional macro AXI_4K_CHECK_EN builds the CMD_ERR protocol checks; otherwise CMD_ERR is tied low.
module axi_burst_addr_gen
   import axi_pkg::*;
#(
   parameter int AXI_DW     = 128,
   parameter int AXI_AW     = 40,
   parameter int AXI_IW     = 8,
   parameter int AXI_LW     = 8,
   parameter int AXI_SW     = 3,
   parameter int AXI_BURSTW = 2,
   parameter int AXI_WSTRBW = AXI_DW / 8
) (
   input  logic                  ACLK,
   input  logic                  ARESETn,
   input  logic                  CMD_VALID,
   output logic                  CMD_READY,
   input  logic [AXI_IW-1:0]     CMD_ID,
   input  logic [AXI_AW-1:0]     CMD_ADDR,
   input  logic [AXI_LW-1:0]     CMD_LEN,
   input  logic [AXI_SW-1:0]     CMD_SIZE,
   input  logic [AXI_BURSTW-1:0] CMD_BURST,
   output logic                  BEAT_VALID,
   input  logic                  BEAT_READY,
   output logic [AXI_IW-1:0]     BEAT_ID,
   output logic [AXI_AW-1:0]     BEAT_ADDR,
   output logic [AXI_WSTRBW-1:0] BEAT_STRB,
   output logic [AXI_LW-1:0]     BEAT_IDX,
   output logic                  BEAT_LAST,
   output logic                  CMD_ERR
);

   localparam int AXI_SIZE_MAX = axi_size_max(AXI_WSTRBW);
   localparam int OFFW         = (AXI_SIZE_MAX > 0) ? AXI_SIZE_MAX : 1;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BURST = 1'b1;

   logic [0:0]            state;
   logic [AXI_IW-1:0]     id_q;
   logic [AXI_AW-1:0]     addr_q;
   logic [AXI_AW-1:0]     lower_q;
   logic [AXI_AW-1:0]     wrap_bytes_q;
   logic [AXI_LW-1:0]     len_q;
   logic [AXI_LW-1:0]     idx_q;
   logic [AXI_SW-1:0]     size_q;
   burst_t                burst_q;

   logic                  busy;
   logic                  accept;
   logic                  beat_hs;
   logic                  last;
   logic [AXI_SW-1:0]     size_c;
   logic                  wrap_len_ok;
   burst_t                burst_raw;
   burst_t                burst_c;
   logic [AXI_AW-1:0]     cmd_wrap_bytes;
   logic [AXI_AW-1:0]     cmd_lower;
   logic [AXI_AW-1:0]     nbytes_q;
   logic [AXI_AW-1:0]     incr_q;
   logic [AXI_AW-1:0]     next_addr;
   logic [AXI_WSTRBW-1:0] strb_w;

   assign busy    = (state == ST_BURST);
   assign accept  = CMD_VALID && !busy;
   assign beat_hs = busy && BEAT_READY;
   assign last    = (idx_q == len_q);

   assign burst_raw   = burst_t'(CMD_BURST[AXI_BURST_TW-1:0]);
   assign wrap_len_ok = (CMD_LEN == AXI_LW'(1)) || (CMD_LEN == AXI_LW'(3)) ||
                        (CMD_LEN == AXI_LW'(7)) || (CMD_LEN == AXI_LW'(15));

   always_comb begin
      size_c = (CMD_SIZE > AXI_SW'(AXI_SIZE_MAX)) ? AXI_SW'(AXI_SIZE_MAX) : CMD_SIZE;
      // Illegal WRAP lengths and the reserved encoding both degrade to INCR.
      case (burst_raw)
         BURST_FIXED: burst_c = BURST_FIXED;
         BURST_WRAP:  burst_c = wrap_len_ok ? BURST_WRAP : BURST_INCR;
         default:     burst_c = BURST_INCR;
      endcase
      cmd_wrap_bytes = (AXI_AW'(CMD_LEN) + AXI_AW'(1)) << size_c;
      cmd_lower      = CMD_ADDR & ~(cmd_wrap_bytes - AXI_AW'(1));
   end

   always_comb begin
      nbytes_q = AXI_AW'(1) << size_q;
      incr_q   = (addr_q & ~(nbytes_q - AXI_AW'(1))) + nbytes_q;
      case (burst_q)
         BURST_FIXED: next_addr = addr_q;
         BURST_WRAP:  next_addr = (incr_q == lower_q + wrap_bytes_q) ? lower_q : incr_q;
         default:     next_addr = incr_q;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state        <= ST_IDLE;
         id_q         <= '0;
         addr_q       <= '0;
         lower_q      <= '0;
         wrap_bytes_q <= '0;
         len_q        <= '0;
         idx_q        <= '0;
         size_q       <= '0;
         burst_q      <= BURST_FIXED;
      end else if (accept) begin
         state        <= ST_BURST;
         id_q         <= CMD_ID;
         addr_q       <= CMD_ADDR;
         lower_q      <= cmd_lower;
         wrap_bytes_q <= cmd_wrap_bytes;
         len_q        <= CMD_LEN;
         idx_q        <= '0;
         size_q       <= size_c;
         burst_q      <= burst_c;
      end else if (beat_hs) begin
         if (last) begin
            state <= ST_IDLE;
         end else begin
            addr_q <= next_addr;
            idx_q  <= idx_q + AXI_LW'(1);
         end
      end
   end

   axi_strb_gen #(
      .AXI_WSTRBW (AXI_WSTRBW),
      .AXI_SW     (AXI_SW),
      .OFFW       (OFFW)
   ) u_strb_gen (
      .addr (addr_q[OFFW-1:0]),
      .size (size_q),
      .strb (strb_w)
   );

   // Descriptor fields read as zero whenever no beat is being presented.
   assign CMD_READY  = !busy;
   assign BEAT_VALID = busy;
   assign BEAT_ID    = busy ? id_q   : '0;
   assign BEAT_ADDR  = busy ? addr_q : '0;
   assign BEAT_STRB  = busy ? strb_w : '0;
   assign BEAT_IDX   = busy ? idx_q  : '0;
   assign BEAT_LAST  = busy && last;

`ifdef AXI_4K_CHECK_EN
   localparam int PAGE_BITS = $clog2(AXI_4KB);

   logic [AXI_AW-1:0] nb_c;
   logic [AXI_AW-1:0] end_c;
   logic              err_c;
   logic              err_q;

   always_comb begin
      nb_c  = AXI_AW'(1) << size_c;
      end_c = (CMD_ADDR & ~(nb_c - AXI_AW'(1))) + cmd_wrap_bytes - AXI_AW'(1);
      err_c = 1'b0;
      if (burst_raw == BURST_INCR && end_c[AXI_AW-1:PAGE_BITS] != CMD_ADDR[AXI_AW-1:PAGE_BITS]) begin
         err_c = 1'b1;
      end
      if (burst_raw == BURST_WRAP && (!wrap_len_ok || (CMD_ADDR & (nb_c - AXI_AW'(1))) != '0)) begin
         err_c = 1'b1;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         err_q <= 1'b0;
      end else begin
         err_q <= accept && err_c;
      end
   end

   assign CMD_ERR = err_q;
`else
   assign CMD_ERR = 1'b0;
`endif

endmodule
`default_nettype wire
